ai_wload: RTL
=============

Name: ai_wload

Overview:
- Weight-load sequencer that sits directly upstream of the two-layer network top.
- Accepts a host stream of 2n-bit fixed-point weight words over a valid/ready handshake.
- Drives the shared `bus` and the per-node `we` shift enables so each node's weight shift register is filled in order.
- Signals completion once all `wt` words are delivered; tri-states `bus` when idle so other agents may use it.

Parameters:
- sx, 99, inputs per layer-1 node (network input count)
- sl1, 99, layer-1 node count = inputs per output-layer node
- sl, 99, output-layer node count
- nd, 99, total nodes; must equal sl1+sl
- wt, 99, total weights; must equal sx*sl1 + sl1*sl
- n (localparam), `n from fixed_point.vh, base word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- s_data  in  2n  signed weight word from host
- s_valid  in  1  s_data valid
- s_ready  out  1  sequencer can accept a word
- we  out  nd  one-hot node shift enable; bit nd-1 = first layer-1 node
- bus  inout  2n  shared weight bus; driven only while loading a word, else high-Z
- busy  out  1  load in progress
- done  out  1  one-cycle pulse after the last word is presented on bus
- node_idx  out  clog2(nd)  node currently being filled

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; we=0; bus high-Z; s_ready=0; busy=0; done=0; node_idx=nd-1; word counter=0.
  - Reset mid-load aborts immediately; no partial resume.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - s_ready=0; start=1 -> LOAD, busy=1, node_idx=nd-1, wcnt=0.
  - s_valid is ignored.
- LOAD:
  - s_ready=1.
  - A transfer occurs on a cycle where s_valid & s_ready. On transfer in cycle t:
    - cycle t+1: bus=s_data (registered); we has exactly bit node_idx set for one cycle.
  - Back-to-back transfers are allowed: one word per cycle.
  - When s_valid=0: we=0 next cycle and bus goes high-Z.
- Words per node:
  - Nodes nd-1 down to sl (layer 1) take sx words each.
  - Nodes sl-1 down to 0 (output layer) take sl1 words each.
  - When wcnt reaches the node's count-1 on a transfer: wcnt=0, node_idx decrements.
- Last word of node 0 accepted -> FLUSH; s_ready drops to 0 in the same next edge.
- FLUSH (1 cycle):
  - Last word is on bus with we[0]=1.
  - done=1; next state IDLE; busy=0 in IDLE.
- start while busy: ignored.
- Data path: s_data is passed unmodified, no arithmetic. Words are signed Q-format per fixed_point.vh.
- Total accepted transfers per load = wt exactly.
- Elaboration check: nd!=sl1+sl or wt mismatch -> $error.

Optional Feature:
- Macro: WLOAD_CHECKSUM_EN.
- When defined:
  - Adds output `csum` [2n-1:0]: wrapping (mod 2^2n) sum of all words accepted in the current load.
  - Cleared on start and on reset; final value valid in the done cycle and held until the next start.
- When undefined: the port and the accumulator are absent. Other behaviour is identical.

Decomposition:
- Package ai_pkg:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2).
  - clog2 function.
  - `n re-exported as a constant.
- Sub-module wload_cnt: word/node down-counter pair.
  - Inputs: adv, per-node length select.
  - Outputs: node_idx, last_word, last_node.

Test Plan (sx=3, sl1=2, sl=1, nd=3, wt=8):
- Reset then start; stream 8 back-to-back words 0x0001..0x0008:
  - we=3'b100 for words 1-3, 3'b010 for words 4-6, 3'b001 for words 7-8.
  - bus matches each word one cycle after its transfer.
  - done pulses in the cycle bus=0x0008; busy falls the next cycle.
- Same stream with s_valid low every other cycle: we is zero and bus is Z on idle cycles; word/node mapping unchanged.
- start pulsed again during LOAD after word 2: ignored; mapping and total of 8 transfers unchanged.
- rst asserted after word 5: we=0, bus=Z, busy=0 asynchronously; a new start reloads from node 2 word 0.
- With WLOAD_CHECKSUM_EN, words 0x7FFF,0x0001, then 0xFFFF x6: csum=0x7FFA at done.

Source files
------------

// File: rtl/ai_pkg.sv
`default_nettype none
//==============================================================================
// ai_pkg - shared constants, state encoding and sizing helpers for ai_wload
// Rev 1.0
//==============================================================================
package ai_pkg;

    // Base word width of the fixed-point format
    localparam int N = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_LOAD  = LOAD,
        ST_FLUSH = FLUSH
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Vector width that never collapses to zero bits
    function automatic int idx_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ai_wload_if.sv
`default_nettype none
//==============================================================================
// ai_wload_if - host stream and node-enable bundle; csum only with WLOAD_CHECKSUM_EN
// Rev 1.0
//==============================================================================
interface ai_wload_if
   import ai_pkg::*;
#(
   parameter int nd = 3,
   parameter int BW = 2 * N
) ();

   localparam int IW = idx_w(nd);

   logic          start;
   logic [BW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [nd-1:0] we;
   logic          busy;
   logic          done;
   logic [IW-1:0] node_idx;
`ifdef WLOAD_CHECKSUM_EN
   logic [BW-1:0] csum;

   modport master (
      output start, s_data, s_valid,
      input  s_ready, we, busy, done, node_idx, csum
   );
   modport slave (
      input  start, s_data, s_valid,
      output s_ready, we, busy, done, node_idx, csum
   );
`else
   modport master (
      output start, s_data, s_valid,
      input  s_ready, we, busy, done, node_idx
   );
   modport slave (
      input  start, s_data, s_valid,
      output s_ready, we, busy, done, node_idx
   );
`endif

endinterface
`default_nettype wire

// File: rtl/wload_cnt.sv
`default_nettype none
//==============================================================================
// wload_cnt - word-within-node and node down-counter pair for the weight loader
// Rev 1.0
//==============================================================================
module wload_cnt
   import ai_pkg::*;
#(
   parameter int sx  = 3,
   parameter int sl1 = 2,
   parameter int nd  = 3
) (
   input  wire                     clk,
   input  wire                     rst,
   input  wire                     clr,
   input  wire                     adv,
   input  wire                     len_sel,
   output logic [idx_w(nd)-1:0]    node_idx,
   output logic                    last_word,
   output logic                    last_node
);

   localparam int CW = idx_w((sx > sl1) ? sx : sl1);
   localparam int IW = idx_w(nd);

   localparam logic [CW-1:0] LEN_L1 = CW'(sx - 1);
   localparam logic [CW-1:0] LEN_L2 = CW'(sl1 - 1);
   localparam logic [IW-1:0] TOP    = IW'(nd - 1);

   logic [CW-1:0] wcnt;
   logic [CW-1:0] wmax;

   // len_sel high selects a layer-1 node (sx words), low an output node (sl1 words)
   assign wmax      = len_sel ? LEN_L1 : LEN_L2;
   assign last_word = (wcnt == wmax);
   assign last_node = (node_idx == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt     <= '0;
         node_idx <= TOP;
      end else if (clr) begin
         wcnt     <= '0;
         node_idx <= TOP;
      end else if (adv) begin
         if (last_word) begin
            wcnt     <= '0;
            // Finishing node 0 rearms the pointer for the next load
            node_idx <= last_node ? TOP : node_idx - IW'(1);
         end else begin
            wcnt <= wcnt + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ai_wload.sv
`default_nettype none
//==============================================================================
// ai_wload - weight-load sequencer feeding node shift registers over a shared bus
// Rev 1.0   (WLOAD_CHECKSUM_EN adds a running csum of accepted words)
//==============================================================================
module ai_wload
   import ai_pkg::*;
#(
   parameter int sx  = 99,
   parameter int sl1 = 99,
   parameter int sl  = 99,
   parameter int nd  = sl1 + sl,
   parameter int wt  = sx * sl1 + sl1 * sl
) (
   input  wire              clk,
   input  wire              rst,
   ai_wload_if.slave        wl,
   inout  wire [2*N-1:0]    bus
);

   localparam int BW = 2 * N;
   localparam int IW = idx_w(nd);
   localparam logic [nd-1:0] ONE = nd'(1);

   if (nd != sl1 + sl) begin : g_bad_nd
      $error("ai_wload: nd=%0d does not equal sl1+sl=%0d", nd, sl1 + sl);
   end
   if (wt != sx * sl1 + sl1 * sl) begin : g_bad_wt
      $error("ai_wload: wt=%0d does not equal sx*sl1+sl1*sl=%0d", wt, sx * sl1 + sl1 * sl);
   end

   state_t        state;
   state_t        state_nx;
   logic          rdy;
   logic          busy_c;
   logic          done_c;
   logic          load_go;
   logic          fire;
   logic          len_sel;
   logic          last_word;
   logic          last_node;
   logic [IW-1:0] node_idx;
   logic [BW-1:0] bus_q;
   logic          bus_en;
   logic [nd-1:0] we_q;

   assign fire    = wl.s_valid & rdy;
   assign len_sel = (int'(node_idx) >= sl);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rdy      = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      load_go  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wl.start) begin
               state_nx = ST_LOAD;
               load_go  = 1'b1;
            end
         end
         ST_LOAD: begin
            rdy    = 1'b1;
            busy_c = 1'b1;
            if (wl.s_valid && last_word && last_node) state_nx = ST_FLUSH;
         end
         ST_FLUSH: begin
            // Final word sits on the bus this cycle with we[0] set
            busy_c   = 1'b1;
            done_c   = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   wload_cnt #(
      .sx  (sx),
      .sl1 (sl1),
      .nd  (nd)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (load_go),
      .adv       (fire),
      .len_sel   (len_sel),
      .node_idx  (node_idx),
      .last_word (last_word),
      .last_node (last_node)
   );

   // Each accepted word is presented for exactly one cycle, then the bus is released
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_q  <= '0;
         bus_en <= 1'b0;
         we_q   <= '0;
      end else begin
         bus_en <= fire;
         we_q   <= fire ? (ONE << node_idx) : '0;
         if (fire) bus_q <= wl.s_data;
      end
   end

   assign bus         = bus_en ? bus_q : {BW{1'bz}};
   assign wl.we       = we_q;
   assign wl.s_ready  = rdy;
   assign wl.busy     = busy_c;
   assign wl.done     = done_c;
   assign wl.node_idx = node_idx;

`ifdef WLOAD_CHECKSUM_EN
   logic [BW-1:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         csum_q <= '0;
      else if (load_go) csum_q <= '0;
      else if (fire)    csum_q <= csum_q + wl.s_data;
   end

   assign wl.csum = csum_q;
`endif

endmodule
`default_nettype wire
